// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int MIN_LATENCY = 1;
    localparam int MAX_LATENCY = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker: bit 0 is fetch, bit 1 is data.
// On a tie the requester that did not own the last access wins.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = OWN_I;
        grant  = 2'b00;
        unique case (req)
            2'b01:   winner = OWN_I;
            2'b10:   winner = OWN_D;
            2'b11:   winner = ~last;
            default: winner = OWN_I;
        endcase
        if (req != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the fetch and data ports,
// one transaction in flight, round-robin on contention.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN    = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic [WORD_LEN-1:0] m_addr,
    output logic                m_wen,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata
);

    if (MEM_LATENCY < MIN_LATENCY || MEM_LATENCY > MAX_LATENCY) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    arb_state_e          state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;

    logic [1:0] arb_req;
    logic [1:0] arb_grant;
    logic       arb_winner;

    // Reset outranks a same-cycle request: nothing reaches the picker.
    assign arb_req = (state_q == ARB_IDLE && !rst) ? {d_req, i_req} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req    (arb_req),
        .last   (last_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = wen_q;
        owner_d  = owner_q;
        last_d   = last_q;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        m_addr   = '0;
        m_wen    = 1'b0;
        m_wdata  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                i_gnt = arb_grant[0];
                d_gnt = arb_grant[1];
                if (arb_grant != 2'b00) begin
                    owner_d = arb_winner;
                    addr_d  = arb_winner ? d_addr : i_addr;
                    wdata_d = arb_winner ? d_wdata : '0;
                    wen_d   = arb_winner & d_wen;
                    cnt_d   = CNT_INIT;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                m_addr  = addr_q;
                m_wdata = wdata_q;
                // cnt only counts down, so CNT_INIT marks the first cycle
                m_wen   = wen_q && (cnt_q == CNT_INIT);
                if (cnt_q == 2'd0) begin
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ARB_RESP: begin
                m_addr  = addr_q;
                last_d  = owner_q;
                state_d = ARB_IDLE;
                if (owner_q == OWN_D) begin
                    d_rvalid = 1'b1;
                    d_rdata  = wen_q ? '0 : m_rdata;
                end else begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the core's instruction-fetch port and data port.
- Each requester gets a req/gnt/rvalid handshake. One transaction is in flight at a time.
- Round-robin arbitration on contention. The arbiter holds the memory address and write controls for the whole access.
- Lets the multi-cycle core run from a unified instruction/data memory.

Parameters:
- WORD_LEN, 32, data and address width.
- MEM_LATENCY, 1, cycles from address presented to m_rdata valid; legal range 1..4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- i_req  input  1  fetch request; held high until i_gnt
- i_addr  input  WORD_LEN  fetch address; stable while i_req is high
- i_gnt  output  1  fetch accepted; one-cycle pulse
- i_rvalid  output  1  fetch data valid; one-cycle pulse
- i_rdata  output  WORD_LEN  fetch data; valid only with i_rvalid
- d_req  input  1  data request; held high until d_gnt
- d_wen  input  1  1 = write, 0 = read; stable while d_req is high
- d_addr  input  WORD_LEN  data address
- d_wdata  input  WORD_LEN  write data
- d_gnt  output  1  data request accepted; one-cycle pulse
- d_rvalid  output  1  read data valid, or write acknowledge; one-cycle pulse
- d_rdata  output  WORD_LEN  read data; 0 for write acknowledge
- m_addr  output  WORD_LEN  memory address
- m_wen  output  1  memory write enable
- m_wdata  output  WORD_LEN  memory write data
- m_rdata  input  WORD_LEN  memory read data

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE, last_owner=D (so fetch wins the first tie).
  - All gnt/rvalid/m_wen = 0.
  - m_addr, m_wdata, rdata outputs = 0.
- Registered request state: addr_q, wdata_q, wen_q, owner_q, cnt (2 bits).
- State machine:
  - IDLE:
    - If any req is high, pick a winner combinationally and assert its gnt in this same cycle.
    - Capture the winner's addr, wdata and wen (wen forced to 0 for fetch) into the registers; set owner_q to the winner.
    - Load cnt = MEM_LATENCY-1 and go to BUSY.
    - If no req is high: stay in IDLE, all outputs 0.
  - BUSY:
    - m_addr=addr_q, m_wdata=wdata_q.
    - m_wen = wen_q only in the first BUSY cycle.
    - cnt decrements each cycle; when cnt==0, go to RESP.
    - Length is exactly MEM_LATENCY cycles.
  - RESP:
    - m_addr held at addr_q.
    - Owner's rvalid=1 for one cycle. Owner's rdata = m_rdata for a read, 0 for a write.
    - last_owner=owner_q; next state is IDLE.
    - No new grant is issued in RESP.
- Arbitration: with both reqs high in IDLE, grant the requester that is not last_owner. A single requester always wins.
- Timing:
  - Grant at cycle T gives rvalid at T+MEM_LATENCY+1.
  - Next grant no earlier than T+MEM_LATENCY+2.
  - Throughput is 1 access per MEM_LATENCY+2 cycles.
- Outputs are decoded from registered state and owner_q; the only combinational paths are gnt from req in IDLE and rdata from m_rdata in RESP.
- Boundaries and error cases:
  - Requester changing addr after gnt: no effect, since the transaction was captured at grant.
  - req dropped before gnt: no transaction.
  - req still high in RESP: not granted until the following IDLE cycle.
  - rst during BUSY or RESP: next cycle is IDLE with all outputs 0; no rvalid is issued for the aborted transaction. A write whose m_wen cycle already occurred is not undone.
  - Simultaneous rst and req: rst wins; no grant.
  - cnt must never underflow. MEM_LATENCY outside 1..4 is an elaboration error.

Decomposition:
- Shared constants go in consts.vh next to the existing core constants:
  - state encodings ARB_IDLE/ARB_BUSY/ARB_RESP (2 bits)
  - owner encodings OWN_I=0, OWN_D=1
- One sub-module: rr_arb2, a two-requester round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot grant, winner index.
  - Combinational; reused later for any further shared ports.

Test Plan:
- MEM_LATENCY=1, i_req alone at addr 0x0000_0010, memory returns 0x00A0_0093 → i_gnt in cycle 0, BUSY in cycle 1 with m_addr=0x10, i_rvalid with i_rdata=0x00A0_0093 in cycle 2, IDLE in cycle 3.
- Data write d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF → m_wen high for exactly one cycle with those values; d_rvalid after MEM_LATENCY+1 cycles with d_rdata=0; memory readback returns 0xDEAD_BEEF.
- i_req and d_req held high together for 6 transactions → grants alternate I,D,I,D,I,D; the first is I after reset; no requester waits more than one transaction.
- MEM_LATENCY=3, data read of 0x0000_0104 → rvalid exactly 4 cycles after d_gnt; m_addr held at 0x104 through BUSY and RESP; i_req raised mid-transaction is granted only after RESP.
- rst asserted in the second BUSY cycle of a read → next cycle is IDLE with all outputs 0, no rvalid ever issued, and the next request is granted normally with I-first priority.
